// File: rtl/key_click_if.sv
// Key click classifier bus: press pulses in, click classifications out.
// triple_click exists only when KEY_CLICK_TRIPLE_EN is defined.
interface key_click_if #(
    parameter int KEY_W = 3
);
    logic [KEY_W-1:0] key_pulse;
    logic [KEY_W-1:0] single_click;
    logic [KEY_W-1:0] double_click;
`ifdef KEY_CLICK_TRIPLE_EN
    logic [KEY_W-1:0] triple_click;

    modport master (output key_pulse, input single_click, double_click, triple_click);
    modport slave  (input key_pulse, output single_click, double_click, triple_click);
`else
    modport master (output key_pulse, input single_click, double_click);
    modport slave  (input key_pulse, output single_click, double_click);
`endif
endinterface

// File: rtl/key_click_decoder.sv
// Per-key single/double click classifier behind the key debouncer.
// Optional triple-click detection is enabled by defining KEY_CLICK_TRIPLE_EN.
//
// state | meaning
// IDLE  | no click pending
// WAIT2 | one click seen, window open for a second
// WAIT3 | two clicks seen, window open for a third (KEY_CLICK_TRIPLE_EN only)
module key_click_decoder #(
    parameter int KEY_W    = 3,
    parameter int TIME_WIN = 25_000_000,
    parameter int CNT_W    = $clog2(TIME_WIN)
) (
    input  logic        clk,
    input  logic        rst_n,
    key_click_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT2 = 2'd1,
        S_WAIT3 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIME_WIN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q [KEY_W];
    state_t           state_d [KEY_W];
    logic [CNT_W-1:0] cnt_q   [KEY_W];
    logic [CNT_W-1:0] cnt_d   [KEY_W];

    logic [KEY_W-1:0] key_pulse_dly_q;
    logic [KEY_W-1:0] key_evt;
    logic [KEY_W-1:0] single_q, single_d;
    logic [KEY_W-1:0] double_q, double_d;
`ifdef KEY_CLICK_TRIPLE_EN
    logic [KEY_W-1:0] triple_q, triple_d;
`endif

    // A held input yields a single event on its rising edge only.
    assign key_evt = bus.key_pulse & ~key_pulse_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_pulse_dly_q <= '0;
            single_q        <= '0;
            double_q        <= '0;
`ifdef KEY_CLICK_TRIPLE_EN
            triple_q        <= '0;
`endif
            for (int i = 0; i < KEY_W; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            key_pulse_dly_q <= bus.key_pulse;
            single_q        <= single_d;
            double_q        <= double_d;
`ifdef KEY_CLICK_TRIPLE_EN
            triple_q        <= triple_d;
`endif
            for (int i = 0; i < KEY_W; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // The event check precedes the timeout check so an event on the last
    // window cycle still counts as a further click.
    always_comb begin
        for (int i = 0; i < KEY_W; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (key_evt[i]) begin
                        state_d[i] = S_WAIT2;
                        cnt_d[i]   = '0;
                    end
                end
                S_WAIT2: begin
                    if (key_evt[i]) begin
`ifdef KEY_CLICK_TRIPLE_EN
                        state_d[i] = S_WAIT3;
`else
                        state_d[i] = S_IDLE;
`endif
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
`ifdef KEY_CLICK_TRIPLE_EN
                S_WAIT3: begin
                    if (key_evt[i] || (cnt_q[i] == CNT_LAST)) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
`endif
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        single_d = '0;
        double_d = '0;
`ifdef KEY_CLICK_TRIPLE_EN
        triple_d = '0;
`endif
        for (int i = 0; i < KEY_W; i++) begin
            single_d[i] = (state_q[i] == S_WAIT2) && !key_evt[i] && (cnt_q[i] == CNT_LAST);
`ifdef KEY_CLICK_TRIPLE_EN
            double_d[i] = (state_q[i] == S_WAIT3) && !key_evt[i] && (cnt_q[i] == CNT_LAST);
            triple_d[i] = (state_q[i] == S_WAIT3) && key_evt[i];
`else
            double_d[i] = (state_q[i] == S_WAIT2) && key_evt[i];
`endif
        end
    end

    assign bus.single_click = single_q;
    assign bus.double_click = double_q;
`ifdef KEY_CLICK_TRIPLE_EN
    assign bus.triple_click = triple_q;
`endif

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder with TIME_WIN=50 and a 20 ns clock.
// Covers both builds; KEY_CLICK_TRIPLE_EN selects the triple-click checks.
module tb_key_click_decoder;

    localparam int KEY_W    = 3;
    localparam int TIME_WIN = 50;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    int sc_tot [KEY_W];
    int dc_tot [KEY_W];
    int sc_base [KEY_W];
    int dc_base [KEY_W];

    key_click_if #(.KEY_W(KEY_W)) kif ();

    key_click_decoder #(
        .KEY_W    (KEY_W),
        .TIME_WIN (TIME_WIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        for (int k = 0; k < KEY_W; k++) begin
            sc_tot[k] = 0;
            dc_tot[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < KEY_W; k++) begin
            sc_tot[k] = sc_tot[k] + int'(kif.single_click[k]);
            dc_tot[k] = dc_tot[k] + int'(kif.double_click[k]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [KEY_W-1:0] m);
        kif.key_pulse = m;
        step(1);
        kif.key_pulse = '0;
    endtask

    task automatic snap();
        for (int k = 0; k < KEY_W; k++) begin
            sc_base[k] = sc_tot[k];
            dc_base[k] = dc_tot[k];
        end
    endtask

    // Expected per-key pulse counts since the last snap, one byte per key.
    task automatic chk_cnt(input string tag, input logic [23:0] exp_sc, input logic [23:0] exp_dc);
        logic [23:0] got_sc;
        logic [23:0] got_dc;
        for (int k = 0; k < KEY_W; k++) begin
            got_sc[k*8 +: 8] = 8'(sc_tot[k] - sc_base[k]);
            got_dc[k*8 +: 8] = 8'(dc_tot[k] - dc_base[k]);
        end
        chk({tag, "_sc"}, 32'(got_sc), 32'(exp_sc));
        chk({tag, "_dc"}, 32'(got_dc), 32'(exp_dc));
    endtask

    initial begin
        vec_cnt       = 0;
        err_cnt       = 0;
        rst_n         = 1'b0;
        kif.key_pulse = '0;

        // reset held 3 cycles, then 200 quiet cycles
        for (int c = 0; c < 3; c++) begin
            step(1);
            chk("rst_single", 32'(kif.single_click), 32'h0);
            chk("rst_double", 32'(kif.double_click), 32'h0);
        end
        rst_n = 1'b1;
        snap();
        step(200);
        chk_cnt("idle", 24'h0, 24'h0);

        // single click on key 1
        snap();
        pulse(3'b010);
        step(49);
        chk("single_k1_early", 32'(kif.single_click), 32'h0);
        step(1);
        chk("single_k1", 32'(kif.single_click), 32'h2);
        chk("single_k1_nodbl", 32'(kif.double_click), 32'h0);
        step(1);
        chk("single_k1_width", 32'(kif.single_click), 32'h0);
        step(10);
        chk_cnt("single_k1", 24'h000100, 24'h0);

        // key 0 double click, pulses 10 cycles apart
        snap();
        pulse(3'b001);
        step(9);
        pulse(3'b001);
`ifdef KEY_CLICK_TRIPLE_EN
        chk("dbl_k0_notyet", 32'(kif.double_click), 32'h0);
        step(49);
        chk("dbl_k0_early", 32'(kif.double_click), 32'h0);
        step(1);
        chk("dbl_k0_timeout", 32'(kif.double_click), 32'h1);
`else
        chk("dbl_k0", 32'(kif.double_click), 32'h1);
        step(1);
        chk("dbl_k0_width", 32'(kif.double_click), 32'h0);
`endif
        step(60);
        chk_cnt("dbl_k0", 24'h0, 24'h000001);

        // minimum two-cycle gap still forms a second click
        snap();
        pulse(3'b001);
        step(1);
        pulse(3'b001);
        step(60);
        chk_cnt("min_gap", 24'h0, 24'h000001);

        // second click on key 2 at counter 49: event beats timeout
        snap();
        pulse(3'b100);
        step(49);
        pulse(3'b100);
`ifndef KEY_CLICK_TRIPLE_EN
        chk("edge49_dbl", 32'(kif.double_click), 32'h4);
`endif
        chk("edge49_nosgl", 32'(kif.single_click), 32'h0);
        step(60);
        chk_cnt("edge49", 24'h0, 24'h010000);

        // second pulse 51 cycles later: single, then a fresh window
        snap();
        pulse(3'b100);
        step(50);
        chk("late_single", 32'(kif.single_click), 32'h4);
        pulse(3'b100);
        chk("late_single_width", 32'(kif.single_click), 32'h0);
        step(49);
        chk("late_new_early", 32'(kif.single_click), 32'h0);
        step(1);
        chk("late_new_single", 32'(kif.single_click), 32'h4);
        step(10);
        chk_cnt("late", 24'h020000, 24'h0);

        // all keys held high for 100 cycles count as one event each
        snap();
        kif.key_pulse = 3'b111;
        step(50);
        chk("held_early", 32'(kif.single_click), 32'h0);
        step(1);
        chk("held_single", 32'(kif.single_click), 32'h7);
        step(49);
        kif.key_pulse = '0;
        step(60);
        chk_cnt("held", 24'h010101, 24'h0);

`ifdef KEY_CLICK_TRIPLE_EN
        // triple click on key 0
        snap();
        pulse(3'b001);
        step(9);
        pulse(3'b001);
        step(9);
        pulse(3'b001);
        chk("triple_k0", 32'(kif.triple_click), 32'h1);
        chk("triple_k0_nodbl", 32'(kif.double_click), 32'h0);
        step(1);
        chk("triple_k0_width", 32'(kif.triple_click), 32'h0);
        step(60);
        chk_cnt("triple_k0", 24'h0, 24'h0);
`else
        // overlapping keys: key 0 double while key 1 window runs
        snap();
        pulse(3'b011);
        step(4);
        pulse(3'b001);
        chk("mix_dbl", 32'(kif.double_click), 32'h1);
        step(45);
        chk("mix_single", 32'(kif.single_click), 32'h2);
        step(10);
        chk_cnt("mix", 24'h000100, 24'h000001);
`endif

        // reset mid-window discards the pending click
        snap();
        pulse(3'b001);
        step(20);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(80);
        chk_cnt("rst_mid", 24'h0, 24'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
